// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around a combinational FFT: fill a frame, hold it while the FFT settles, capture the bins, stream them out.
// Optional feature macro: FFT_OVERLAP_EN (50% frame overlap; each frame after the first needs N/2 new samples).
module fft_frame_ctrl #(
    parameter int N          = 256,
    parameter int W          = 16,
    parameter int SETTLE_CYC = 4,
    parameter int OUT_BINS   = N / 2,
    localparam int AW        = $clog2(N),
    localparam int WO        = W + AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  in_sample,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [W-1:0]  fft_x [N][2],
    input  logic signed [WO-1:0] fft_X [N][2],
    output logic signed [WO-1:0] out_re,
    output logic signed [WO-1:0] out_im,
    output logic [AW-1:0]        out_idx,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          frame_cnt
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

`ifdef FFT_OVERLAP_EN
    localparam logic [AW-1:0] WR_START = AW'(N / 2);
`else
    localparam logic [AW-1:0] WR_START = '0;
`endif

    typedef enum logic [1:0] {FILL, SETTLE, CAPTURE, STREAM} state_t;

    state_t                state;
    state_t                state_nxt;
    logic signed [W-1:0]   buf_q   [N];
    logic signed [WO-1:0]  obuf_re [N];
    logic signed [WO-1:0]  obuf_im [N];
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic [AW-1:0]         rd_nxt;
    logic [SW-1:0]         settle_cnt;
    logic                  accept;
    logic                  fire;
    logic [N-1:0]          unused_fft;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready/valid never depend combinationally on the partner's valid/ready.
    assign in_ready = (state == FILL) && !rst;
    assign rd_nxt   = rd_idx + 1'b1;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            fft_x[k][1] = buf_q[k];
            fft_x[k][0] = '0;
        end
    end

    // Bins above OUT_BINS are produced by the FFT but never streamed.
    always_comb begin
        unused_fft = '0;
        for (int k = 0; k < N; k++) begin
            if (k >= OUT_BINS) unused_fft[k] = ^{fft_X[k][1], fft_X[k][0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            FILL: begin
                accept = in_valid;
                if (in_valid && (wr_idx == AW'(N - 1))) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                fire = out_valid && out_ready;
                if (fire && out_last) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) buf_q[k] <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_idx    <= '0;
            out_re     <= '0;
            out_im     <= '0;
            frame_cnt  <= '0;
        end else begin
            if (accept) begin
                buf_q[wr_idx] <= in_sample;
                wr_idx        <= wr_idx + 1'b1;
            end

            if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
            else                 settle_cnt <= '0;

            if (state == CAPTURE) begin
                for (int k = 0; k < OUT_BINS; k++) begin
                    obuf_re[k] <= fft_X[k][1];
                    obuf_im[k] <= fft_X[k][0];
                end
`ifdef FFT_OVERLAP_EN
                // Keep the newer half as the older half of the next frame.
                for (int k = 0; k < N / 2; k++) buf_q[k] <= buf_q[k + N / 2];
`endif
                rd_idx    <= '0;
                out_valid <= 1'b1;
                out_idx   <= '0;
                out_last  <= (OUT_BINS == 1);
                out_re    <= fft_X[0][1];
                out_im    <= fft_X[0][0];
            end

            if (fire) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    frame_cnt <= frame_cnt + 1'b1;
                    wr_idx    <= WR_START;
                end else begin
                    // Output registers load the next bin directly so they stay registered.
                    rd_idx   <= rd_nxt;
                    out_idx  <= rd_nxt;
                    out_last <= (rd_nxt == AW'(OUT_BINS - 1));
                    out_re   <= obuf_re[rd_nxt];
                    out_im   <= obuf_im[rd_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl with a behavioural DFT standing in for the combinational FFT.
module tb_fft_frame_ctrl;
  localparam int N          = 8;
  localparam int W          = 16;
  localparam int SETTLE_CYC = 2;
  localparam int OUT_BINS   = 8;
  localparam int AW         = $clog2(N);
  localparam int WO         = W + AW;
  localparam int EW         = AW + 1 + 2 * WO;
  localparam real PI        = 3.14159265358979;
`ifdef FFT_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [W-1:0]  in_sample = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [W-1:0]  fft_x [N][2];
  logic signed [WO-1:0] fft_X [N][2];
  logic signed [WO-1:0] out_re;
  logic signed [WO-1:0] out_im;
  logic [AW-1:0]        out_idx;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [15:0]          frame_cnt;

  int tests = 0;
  int fails = 0;

  // reference model state
  int            hist_q[$];
  bit            primed = 1'b0;
  logic [15:0]   mdl_cnt = '0;
  logic [EW-1:0] exp_q[$];
  int            obs_re[N];

  fft_frame_ctrl #(.N(N), .W(W), .SETTLE_CYC(SETTLE_CYC), .OUT_BINS(OUT_BINS)) dut (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .fft_x(fft_x), .fft_X(fft_X), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic int dft_part(input int xs[N], input int k, input bit imag);
    real acc;
    real ang;
    acc = 0.0;
    for (int n = 0; n < N; n++) begin
      ang = 2.0 * PI * real'(k * n) / real'(N);
      if (imag) acc = acc - real'(xs[n]) * $sin(ang);
      else      acc = acc + real'(xs[n]) * $cos(ang);
    end
    if (acc >= 0.0) return $rtoi(acc + 0.5);
    return -$rtoi(-acc + 0.5);
  endfunction

  // FFT stand-in, driven only by the DUT's frame view
  int fx[N];
  always_comb begin
    for (int n = 0; n < N; n++) fx[n] = int'(fft_x[n][1]);
  end
  always_comb begin
    for (int k = 0; k < N; k++) begin
      fft_X[k][1] = WO'(dft_part(fx, k, 1'b0));
      fft_X[k][0] = WO'(dft_part(fx, k, 1'b1));
    end
  end

  function automatic int need_now();
    return (primed && OVL) ? N / 2 : N;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    hist_q.delete(); exp_q.delete(); primed = 1'b0; mdl_cnt = '0;
    if (check) begin
      tests++;
      if (out_valid !== 1'b0 || frame_cnt !== 16'h0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL post_reset: valid=%b cnt=%h in_ready=%b, want 0/0000/1", out_valid, frame_cnt, in_ready);
      end
    end
  endtask

  // driver: one frame of new samples, then stream all bins through the scoreboard
  task automatic run_frame(input int vals[$], input bit rand_in, input bit rand_rdy, input int abort_at);
    int idx, guard, waited, nb, bad, base;
    int frame[N];
    logic [EW-1:0] e, got, prev;
    bit held;
    idx = 0; guard = 0;
    while (idx < vals.size() && guard < 1000) begin
      @(negedge clk); guard++;
      in_valid  = rand_in ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_sample = W'(vals[idx]);
      if (in_valid && in_ready) idx++;
    end
    if (idx < vals.size()) begin
      tests++; fails++;
      $display("FAIL fill_timeout: accepted %0d, want %0d", idx, vals.size());
      in_valid = 1'b0;
      return;
    end
    foreach (vals[i]) hist_q.push_back(vals[i]);
    base = hist_q.size() - N;
    for (int k = 0; k < N; k++) frame[k] = hist_q[base + k];
    for (int k = 0; k < OUT_BINS; k++)
      exp_q.push_back({AW'(k), (k == OUT_BINS - 1), WO'(dft_part(frame, k, 1'b0)), WO'(dft_part(frame, k, 1'b1))});

    waited = 0;
    do begin
      @(negedge clk); waited++;
      if (waited == 1) begin
        bad = 0;
        for (int k = 0; k < N; k++)
          if (fft_x[k][1] !== W'(frame[k]) || fft_x[k][0] !== '0) bad++;
        tests++;
        if (bad != 0) begin fails++; $display("FAIL fft_x_frame: %0d entries wrong, want 0", bad); end
      end
      if (out_valid !== 1'b1) begin
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL settle_in_ready: got %b want 0", in_ready); end
      end
      in_valid  = rand_in ? 1'($urandom_range(0, 1)) : 1'b0;
      in_sample = W'(rnd_sample());
    end while (out_valid !== 1'b1 && waited < 50);
    tests++;
    if (waited != SETTLE_CYC + 2) begin
      fails++; $display("FAIL latency: got %0d cycles want %0d", waited, SETTLE_CYC + 2);
    end

    nb = 0; held = 1'b0; guard = 0; prev = '0;
    while (nb < OUT_BINS && guard < 300) begin
      guard++;
      got = {out_idx, out_last, out_re, out_im};
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL stream_flags: valid=%b in_ready=%b want 1/0", out_valid, in_ready);
      end
      if (held) begin
        tests++;
        if (got !== prev) begin fails++; $display("FAIL hold: got %h want %h", got, prev); end
      end
      if (abort_at == nb) begin
        do_reset(1'b1);
        return;
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = rand_in ? 1'($urandom_range(0, 1)) : 1'b0;
      in_sample = W'(rnd_sample());
      if (out_ready) begin
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin fails++; $display("FAIL bin%0d: got %h want %h", nb, got, e); end
        obs_re[nb] = int'(out_re);
        nb++;
      end
      held = !out_ready; prev = got;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (nb < OUT_BINS) begin
      tests++; fails++; $display("FAIL stream_timeout: got %0d bins want %0d", nb, OUT_BINS);
    end
    primed = 1'b1;
    mdl_cnt = mdl_cnt + 16'd1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== mdl_cnt) begin
      fails++;
      $display("FAIL frame_end: valid=%b in_ready=%b cnt=%h, want 0/1/%h", out_valid, in_ready, frame_cnt, mdl_cnt);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < N; k++) if (fft_x[k][1] !== '0 || fft_x[k][0] !== '0) bad++;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_idx !== '0 ||
        out_re !== '0 || out_im !== '0 || frame_cnt !== '0 || bad != 0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b v=%b l=%b idx=%0d re=%0d im=%0d cnt=%h fftx_bad=%0d, want all 0",
               in_ready, out_valid, out_last, out_idx, out_re, out_im, frame_cnt, bad);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_impulse();
    int v[$];
    v.push_back(100);
    for (int i = 1; i < N; i++) v.push_back(0);
    run_frame(v, 1'b0, 1'b0, -1);
    for (int k = 0; k < OUT_BINS; k++) begin
      tests++;
      if (obs_re[k] != 100) begin fails++; $display("FAIL impulse_re%0d: got %0d want 100", k, obs_re[k]); end
    end
    tests++;
    if (frame_cnt !== 16'd1) begin fails++; $display("FAIL impulse_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_dc();
    int v[$];
    do_reset(1'b0);
    for (int i = 0; i < N; i++) v.push_back(1);
    run_frame(v, 1'b0, 1'b0, -1);
    for (int k = 0; k < OUT_BINS; k++) begin
      tests++;
      if (obs_re[k] != ((k == 0) ? N : 0)) begin
        fails++; $display("FAIL dc_re%0d: got %0d want %0d", k, obs_re[k], (k == 0) ? N : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    int v[$];
    do_reset(1'b0);
    for (int i = 1; i <= N; i++) v.push_back(i);
    run_frame(v, 1'b1, 1'b1, -1);
  endtask

  task automatic test_reset_mid_stream();
    int v[$];
    for (int i = 0; i < need_now(); i++) v.push_back(rnd_sample());
    run_frame(v, 1'b0, 1'b0, 3);
    v.delete();
    v.push_back(100);
    for (int i = 1; i < N; i++) v.push_back(0);
    run_frame(v, 1'b0, 1'b1, -1);
    tests++;
    if (obs_re[5] != 100) begin fails++; $display("FAIL post_abort_re5: got %0d want 100", obs_re[5]); end
  endtask

  task automatic test_back_to_back();
    int v[$];
    for (int f = 0; f < 4; f++) begin
      v.delete();
      for (int i = 0; i < need_now(); i++) v.push_back(rnd_sample());
      run_frame(v, f[0], f[1], -1);
    end
  endtask

`ifdef FFT_OVERLAP_EN
  task automatic test_overlap();
    int v[$];
    do_reset(1'b0);
    for (int i = 1; i <= N; i++) v.push_back(i);
    run_frame(v, 1'b0, 1'b0, -1);
    v.delete();
    for (int i = N + 1; i <= N + N / 2; i++) v.push_back(i);
    run_frame(v, 1'b0, 1'b0, -1);
    tests++;
    if (obs_re[0] != 68) begin fails++; $display("FAIL overlap_bin0: got %0d want 68", obs_re[0]); end
  endtask
`endif

  task automatic test_wrap();
    int v[$];
    do_reset(1'b0);
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    mdl_cnt = 16'hFFFF;
    @(negedge clk);
    tests++;
    if (frame_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt); end
    for (int i = 0; i < N; i++) v.push_back(rnd_sample());
    run_frame(v, 1'b0, 1'b0, -1);
    tests++;
    if (frame_cnt !== 16'h0000) begin fails++; $display("FAIL wrap: got %h want 0000", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_backpressure();
    test_reset_mid_stream();
    test_back_to_back();
`ifdef FFT_OVERLAP_EN
    test_overlap();
`endif
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
